// File: rtl/floo_eject_terminator.sv
// Eject-port terminator for stub tiles: sinks request flits and answers each transaction with an error response.
// Response valid the cycle after the last flit; last flits stall on a full response FIFO, others always sink while enabled.

module floo_eject_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_dat_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [Width-1:0] pop_dat_o,
  output logic             empty_o
);
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam logic [AddrW-1:0] LastPtr  = AddrW'(Depth - 1);
  localparam logic [CntW-1:0]  DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o    = (cnt_q == DepthCnt);
  assign empty_o   = (cnt_q == '0);
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;
  assign pop_dat_o = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + AddrW'(1);
    if (do_pop)  rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + AddrW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CntW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: reads are only meaningful when non-empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= push_dat_i;
  end
endmodule

module floo_eject_terminator #(
  parameter int unsigned IdWidth    = 6,
  parameter int unsigned TxnIdWidth = 4,
  parameter int unsigned RspDepth   = 4,
  parameter int unsigned CntWidth   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  clear_i,
  input  logic [IdWidth-1:0]    id_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [IdWidth-1:0]    req_src_id_i,
  input  logic [IdWidth-1:0]    req_dst_id_i,
  input  logic [TxnIdWidth-1:0] req_txn_id_i,
  input  logic                  req_is_write_i,
  input  logic                  req_last_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [IdWidth-1:0]    rsp_src_id_o,
  output logic [IdWidth-1:0]    rsp_dst_id_o,
  output logic [TxnIdWidth-1:0] rsp_txn_id_o,
  output logic                  rsp_is_write_o,
  output logic [1:0]            rsp_err_o,
  output logic [CntWidth-1:0]   flit_cnt_o,
  output logic [CntWidth-1:0]   txn_cnt_o,
  output logic [CntWidth-1:0]   misroute_cnt_o,
  output logic                  proto_err_o,
  output logic                  busy_o
);
  typedef struct packed {
    logic [IdWidth-1:0]    src_id;
    logic [IdWidth-1:0]    dst_id;
    logic [TxnIdWidth-1:0] txn_id;
    logic                  is_write;
    logic [1:0]            err;
  } rsp_t;

  localparam int unsigned RspW = $bits(rsp_t);

  typedef enum logic {ST_IDLE, ST_BURST} state_e;

  state_e                state_q, state_d;
  logic [TxnIdWidth-1:0] burst_txn_q, burst_txn_d;
  logic [IdWidth-1:0]    burst_src_q, burst_src_d;
  logic [CntWidth-1:0]   flit_cnt_q, flit_cnt_d;
  logic [CntWidth-1:0]   txn_cnt_q, txn_cnt_d;
  logic [CntWidth-1:0]   mis_cnt_q, mis_cnt_d;
  logic                  proto_err_q, proto_err_d;

  logic idle_read_open, eff_last, accept, push, misroute, viol;
  logic fifo_full, fifo_empty;
  rsp_t push_rsp, pop_rsp, rsp_out;

  // A multi-flit read seen in IDLE is closed on the spot, so it must also respect FIFO space.
  assign idle_read_open = (state_q == ST_IDLE) & ~req_is_write_i & ~req_last_i;
  assign eff_last       = req_last_i | idle_read_open;
  assign req_ready_o    = en_i & (~eff_last | ~fifo_full);
  assign accept         = req_valid_i & req_ready_o;
  assign push           = accept & eff_last;
  assign misroute       = (req_dst_id_i != id_i);

  always_comb begin
    push_rsp          = '0;
    push_rsp.src_id   = id_i;
    push_rsp.dst_id   = req_src_id_i;
    push_rsp.txn_id   = req_txn_id_i;
    push_rsp.is_write = req_is_write_i;
    push_rsp.err      = misroute ? 2'b10 : 2'b11;
  end

  floo_eject_fifo #(
    .Depth (RspDepth),
    .Width (RspW)
  ) i_rsp_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_dat_i (push_rsp),
    .full_o     (fifo_full),
    .pop_i      (rsp_ready_i),
    .pop_dat_o  (pop_rsp),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    burst_txn_d = burst_txn_q;
    burst_src_d = burst_src_q;
    viol        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_is_write_i && !req_last_i) begin
            state_d     = ST_BURST;
            burst_txn_d = req_txn_id_i;
            burst_src_d = req_src_id_i;
          end
          viol = idle_read_open;
        end
      end
      ST_BURST: begin
        if (accept) begin
          viol = (req_txn_id_i != burst_txn_q) | (req_src_id_i != burst_src_q) | ~req_is_write_i;
          if (req_last_i) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + CntWidth'(1) : v;
  endfunction

  always_comb begin
    flit_cnt_d  = sat_inc(flit_cnt_q, accept);
    txn_cnt_d   = sat_inc(txn_cnt_q, push);
    mis_cnt_d   = sat_inc(mis_cnt_q, push & misroute);
    proto_err_d = proto_err_q | viol;
    if (clear_i) begin
      flit_cnt_d  = '0;
      txn_cnt_d   = '0;
      mis_cnt_d   = '0;
      proto_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      burst_txn_q <= '0;
      burst_src_q <= '0;
      flit_cnt_q  <= '0;
      txn_cnt_q   <= '0;
      mis_cnt_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_txn_q <= burst_txn_d;
      burst_src_q <= burst_src_d;
      flit_cnt_q  <= flit_cnt_d;
      txn_cnt_q   <= txn_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Response fields read as zero when nothing is pending.
  assign rsp_out        = fifo_empty ? '0 : pop_rsp;
  assign rsp_valid_o    = ~fifo_empty;
  assign rsp_src_id_o   = rsp_out.src_id;
  assign rsp_dst_id_o   = rsp_out.dst_id;
  assign rsp_txn_id_o   = rsp_out.txn_id;
  assign rsp_is_write_o = rsp_out.is_write;
  assign rsp_err_o      = rsp_out.err;

  assign flit_cnt_o     = flit_cnt_q;
  assign txn_cnt_o      = txn_cnt_q;
  assign misroute_cnt_o = mis_cnt_q;
  assign proto_err_o    = proto_err_q;
  assign busy_o         = (state_q == ST_BURST) | ~fifo_empty;
endmodule

// File: tb/tb_floo_eject_terminator.sv
// Scoreboard bench for floo_eject_terminator; a second instance with 2-bit counters covers saturation.
`timescale 1ns/1ps
module tb_floo_eject_terminator;
  localparam logic [5:0] MY_ID = 6'd9;

  typedef struct packed {
    logic [5:0] src;
    logic [5:0] dst;
    logic [3:0] txn;
    logic       wr;
    logic [1:0] err;
  } exp_rsp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clear = 1'b0;
  logic [5:0] id = MY_ID;
  logic       req_valid = 1'b0;
  logic [5:0] req_src = '0;
  logic [5:0] req_dst = '0;
  logic [3:0] req_txn = '0;
  logic       req_wr = 1'b0;
  logic       req_last = 1'b0;
  logic       rsp_ready = 1'b0;

  logic        req_ready_o, rsp_valid_o, rsp_is_write_o, proto_err_o, busy_o;
  logic [5:0]  rsp_src_id_o, rsp_dst_id_o;
  logic [3:0]  rsp_txn_id_o;
  logic [1:0]  rsp_err_o;
  logic [15:0] flit_cnt_o, txn_cnt_o, misroute_cnt_o;

  logic        s_req_ready, s_rsp_valid, s_rsp_wr, s_proto, s_busy;
  logic [5:0]  s_rsp_src, s_rsp_dst;
  logic [3:0]  s_rsp_txn;
  logic [1:0]  s_rsp_err;
  logic [1:0]  s_flit_cnt, s_txn_cnt, s_mis_cnt;

  floo_eject_terminator #(.IdWidth(6), .TxnIdWidth(4), .RspDepth(4), .CntWidth(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clear), .id_i(id),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_src_id_i(req_src),
    .req_dst_id_i(req_dst), .req_txn_id_i(req_txn), .req_is_write_i(req_wr),
    .req_last_i(req_last), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
    .rsp_src_id_o(rsp_src_id_o), .rsp_dst_id_o(rsp_dst_id_o), .rsp_txn_id_o(rsp_txn_id_o),
    .rsp_is_write_o(rsp_is_write_o), .rsp_err_o(rsp_err_o), .flit_cnt_o(flit_cnt_o),
    .txn_cnt_o(txn_cnt_o), .misroute_cnt_o(misroute_cnt_o), .proto_err_o(proto_err_o),
    .busy_o(busy_o)
  );

  floo_eject_terminator #(.IdWidth(6), .TxnIdWidth(4), .RspDepth(4), .CntWidth(2)) u_sat (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clear), .id_i(id),
    .req_valid_i(req_valid), .req_ready_o(s_req_ready), .req_src_id_i(req_src),
    .req_dst_id_i(req_dst), .req_txn_id_i(req_txn), .req_is_write_i(req_wr),
    .req_last_i(req_last), .rsp_valid_o(s_rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_src_id_o(s_rsp_src), .rsp_dst_id_o(s_rsp_dst), .rsp_txn_id_o(s_rsp_txn),
    .rsp_is_write_o(s_rsp_wr), .rsp_err_o(s_rsp_err), .flit_cnt_o(s_flit_cnt),
    .txn_cnt_o(s_txn_cnt), .misroute_cnt_o(s_mis_cnt), .proto_err_o(s_proto),
    .busy_o(s_busy)
  );

  always #5 clk = ~clk;

  int       n_checks = 0;
  int       n_fail = 0;
  exp_rsp_t sb_q[$];
  int       exp_flit = 0, exp_txn = 0, exp_mis = 0;
  bit       in_burst = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Response monitor: every handshake pops the oldest expected response.
  initial begin
    exp_rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid_o && rsp_ready) begin
        if (sb_q.size() == 0) check("unexpected_rsp", 1, 0);
        else begin
          e = sb_q.pop_front();
          check("rsp_fields", {13'd0, rsp_src_id_o, rsp_dst_id_o, rsp_txn_id_o, rsp_is_write_o, rsp_err_o}, {13'd0, e});
        end
      end
    end
  end

  task automatic drive(input logic [5:0] src, input logic [5:0] dst, input logic [3:0] txn,
                       input logic wr, input logic last);
    req_src = src; req_dst = dst; req_txn = txn; req_wr = wr; req_last = last;
    req_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int t = 0;
    exp_rsp_t e;
    @(negedge clk);
    while (!req_ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready_o) begin
      check("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    exp_flit++;
    if (req_last || (!req_wr && !in_burst)) begin
      e.src = MY_ID; e.dst = req_src; e.txn = req_txn; e.wr = req_wr;
      e.err = (req_dst == MY_ID) ? 2'b11 : 2'b10;
      sb_q.push_back(e);
      exp_txn++;
      if (req_dst != MY_ID) exp_mis++;
    end
    if (!in_burst && req_wr && !req_last) in_burst = 1'b1;
    else if (in_burst && req_last) in_burst = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic send(input logic [5:0] src, input logic [5:0] dst, input logic [3:0] txn,
                      input logic wr, input logic last);
    drive(src, dst, txn, wr, last);
    wait_accept();
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_flit"}, flit_cnt_o, exp_flit);
    check({tag, "_txn"}, txn_cnt_o, exp_txn);
    check({tag, "_mis"}, misroute_cnt_o, exp_mis);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    exp_flit = 0; exp_txn = 0; exp_mis = 0;
  endtask

  initial begin
    #12;
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_proto", proto_err_o, 0);
    check("rst_ready", req_ready_o, 0);
    check_counters("rst");
    @(posedge clk); #1 rst = 1'b0; en = 1'b1; rsp_ready = 1'b1;

    // Single read, correctly routed; response the cycle after accept.
    send(6'd5, MY_ID, 4'd3, 1'b0, 1'b1);
    check("t1_latency", rsp_valid_o, 1);
    drain();
    check_counters("t1");

    // 4-flit write burst, then misrouted read.
    pulse_clear();
    for (int i = 0; i < 4; i++) begin
      send(6'd5, MY_ID, 4'd7, 1'b1, i == 3);
      if (i == 1) check("t2_busy_burst", busy_o, 1);
    end
    send(6'd5, 6'd2, 4'd1, 1'b0, 1'b1);
    drain();
    check_counters("t2");
    check("t2_proto", proto_err_o, 0);

    // Full FIFO blocks the fifth last flit until responses drain.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(6'd5, MY_ID, 4'(i), 1'b0, 1'b1);
    drive(6'd5, MY_ID, 4'd4, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("t3_full_blocks", req_ready_o, 0);
    end
    check("t3_busy", busy_o, 1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_accept();
    send(6'd5, MY_ID, 4'd5, 1'b0, 1'b1);
    drain();
    check_counters("t3");

    // Transaction ID changes mid-burst; flag is sticky until clear.
    send(6'd5, MY_ID, 4'd2, 1'b1, 1'b0);
    send(6'd5, MY_ID, 4'd4, 1'b1, 1'b1);
    drain();
    check("t4_proto_set", proto_err_o, 1);
    send(6'd5, MY_ID, 4'd8, 1'b0, 1'b1);
    drain();
    check("t4_proto_sticky", proto_err_o, 1);
    check_counters("t4");
    pulse_clear();
    check("t4_proto_clr", proto_err_o, 0);
    check_counters("t4_clr");

    // Saturation on the narrow-counter instance.
    for (int i = 0; i < 5; i++) send(6'd5, 6'd3, 4'(i), 1'b0, 1'b1);
    drain();
    check_counters("t5");
    check("t5_sat_txn", s_txn_cnt, 3);
    check("t5_sat_flit", s_flit_cnt, 3);
    check("t5_sat_mis", s_mis_cnt, 3);

    // Enable drop in the middle of a burst.
    send(6'd1, MY_ID, 4'd5, 1'b1, 1'b0);
    send(6'd1, MY_ID, 4'd5, 1'b1, 1'b0);
    drive(6'd1, MY_ID, 4'd5, 1'b1, 1'b0);
    en = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("t6_ready_low", req_ready_o, 0);
      check("t6_busy", busy_o, 1);
    end
    @(posedge clk); #1 en = 1'b1;
    wait_accept();
    send(6'd1, MY_ID, 4'd5, 1'b1, 1'b1);
    drain();
    check("t6_idle", busy_o, 0);
    check("t6_proto", proto_err_o, 0);
    check_counters("t6");

    // Read without last in IDLE: closed as a transaction, flagged.
    send(6'd7, MY_ID, 4'd6, 1'b0, 1'b0);
    drain();
    check("t7_proto", proto_err_o, 1);
    check_counters("t7");

    // Asynchronous reset with responses pending.
    rsp_ready = 1'b0;
    send(6'd5, MY_ID, 4'd1, 1'b0, 1'b1);
    send(6'd5, MY_ID, 4'd2, 1'b0, 1'b1);
    check("t8_pending", rsp_valid_o, 1);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("t8_async_valid", rsp_valid_o, 0);
    check("t8_async_busy", busy_o, 0);
    sb_q.delete();
    in_burst = 1'b0;
    exp_flit = 0; exp_txn = 0; exp_mis = 0;
    @(posedge clk); #1 rst = 1'b0; rsp_ready = 1'b1;
    check_counters("t8");
    check("t8_proto", proto_err_o, 0);
    repeat (3) @(posedge clk);
    #1 check("t8_no_rsp", rsp_valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/floo_eject_terminator.md
Name: floo_eject_terminator

Overview:
- Active terminator for the Eject port of a NoC stub tile, i.e. a tile that has a router but no compute.
- It replaces hard-tying the Eject inputs to zero: it accepts every request flit the router ejects and returns one error response per transaction.
- It counts terminated traffic and misrouted traffic, and flags protocol violations.
- Parametrised in ID, transaction-ID and counter widths and in response buffering depth, so the same stub serves any mesh position.

Parameters:
- IdWidth, 6, width of router/tile ID fields.
- TxnIdWidth, 4, width of transaction ID.
- RspDepth, 4, depth of pending-response FIFO (>=1).
- CntWidth, 16, width of statistics counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- en_i  in  1  terminate enable; low = backpressure all requests.
- clear_i  in  1  synchronous clear of counters and sticky flag.
- id_i  in  IdWidth  own tile ID.
- req_valid_i  in  1  ejected request flit valid.
- req_ready_o  out  1  request flit accepted.
- req_src_id_i  in  IdWidth  requester ID.
- req_dst_id_i  in  IdWidth  destination ID in flit header.
- req_txn_id_i  in  TxnIdWidth  transaction ID.
- req_is_write_i  in  1  1 = write flit (may be a burst), 0 = read request (single flit).
- req_last_i  in  1  last flit of transaction.
- rsp_valid_o  out  1  response flit valid.
- rsp_ready_i  in  1  router accepts response.
- rsp_src_id_o  out  IdWidth  = id_i captured at accept.
- rsp_dst_id_o  out  IdWidth  = requester ID.
- rsp_txn_id_o  out  TxnIdWidth  echoed transaction ID.
- rsp_is_write_o  out  1  echoed direction.
- rsp_err_o  out  2  2'b11 DECERR (correctly routed), 2'b10 SLVERR (misrouted).
- flit_cnt_o  out  CntWidth  accepted flits, saturating.
- txn_cnt_o  out  CntWidth  responses enqueued, saturating.
- misroute_cnt_o  out  CntWidth  terminated transactions with dst != id_i, saturating.
- proto_err_o  out  1  sticky protocol-violation flag.
- busy_o  out  1  FSM in BURST or FIFO non-empty.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM IDLE, counters 0, proto_err_o 0.
- Handshake: flit transfers when req_valid_i & req_ready_o; response transfers when rsp_valid_o & rsp_ready_i.
- rsp_valid_o stays high until accepted; rsp_* fields stay stable while rsp_valid_o is high.
- Ready rule: req_ready_o = en_i & (~req_last_i | ~fifo_full).
  - Non-last write flits are always sunk while enabled.
  - No combinational path from rsp_ready_i to req_ready_o: a full FIFO blocks a last flit even if a pop occurs that cycle.
- Enqueue: an accepted flit with req_last_i=1 pushes {id_i, req_src_id_i, req_txn_id_i, req_is_write_i, err} into the FIFO.
  - err = (req_dst_id_i == id_i) ? 2'b11 : 2'b10.
- Latency: last flit accepted in cycle N -> rsp_valid_o high in N+1 if the FIFO was empty. Responses leave in FIFO order.
- Simultaneous push and pop while not full: both occur, occupancy unchanged.
- FSM (write-burst tracking):
  - IDLE: an accepted write flit with last=0 captures its txn_id/src_id and moves to BURST. Accepted reads and single-flit writes stay in IDLE.
  - BURST: each accepted flit is checked. proto_err_o is set if any of the following holds:
    - txn_id differs from the captured value;
    - src_id differs from the captured value;
    - is_write=0.
  - BURST: an accepted flit with last=1 returns to IDLE. The response is still enqueued on a violation.
  - A read arriving in IDLE with last=0 sets proto_err_o and is treated as last: it is enqueued and the FSM stays in IDLE.
- Counters:
  - flit_cnt_o +1 per accepted flit.
  - txn_cnt_o +1 per enqueue.
  - misroute_cnt_o +1 per enqueue with SLVERR.
  - All counters saturate at all-ones and do not wrap.
- clear_i: zeroes counters and proto_err_o in the next cycle. If an increment event coincides, clear wins. FIFO and FSM are unaffected.
- en_i low mid-burst: no flits accepted; FSM holds BURST; queued responses keep draining.
- rst_i asserted mid-operation: FIFO flushed, FSM to IDLE, rsp_valid_o drops immediately (asynchronous).

Test Plan:
- Read, src=5, txn=3, dst=id_i=9, rsp_ready_i=1 -> rsp_valid_o in next cycle with dst=5, src=9, txn=3, err=2'b11; txn_cnt_o=1, flit_cnt_o=1.
- 4-flit write burst, txn=7, then 1-flit read with dst=2, id_i=9 -> exactly 2 responses in order: (write, 2'b11), then (read, 2'b10); flit_cnt_o=5, misroute_cnt_o=1.
- rsp_ready_i=0, RspDepth=4, 6 single-flit reads -> 4 accepted, then req_ready_o=0; after releasing rsp_ready_i, 6 responses drain with txn IDs in order.
- Burst with txn_id changing 2->4 on the second flit -> proto_err_o=1 and sticky; 1 response still issued; clear_i pulse -> proto_err_o=0 and all counters 0.
- CntWidth=2, 5 reads -> txn_cnt_o saturates at 3.
- en_i=0 mid-burst for 10 cycles -> req_ready_o=0 and busy_o=1 throughout; on resuming, the burst completes with 1 response.
